// File: rtl/queue_8x72_pkg.sv
// Shared sizing and payload type for the 8-entry x 72-bit queue.
package queue_8x72_pkg;

  localparam int QDEPTH = 8;
  localparam int QWIDTH = 72;
  localparam int PTR_W  = 3;
  localparam int CNT_W  = 4;

  localparam logic [CNT_W-1:0] CNT_EMPTY = 4'd0;
  localparam logic [CNT_W-1:0] CNT_FULL  = 4'd8;

  typedef logic [QWIDTH-1:0] payload_t;

  // Pointer advance; the depth is a power of two so wrap 7->0 is natural overflow.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return p + 3'd1;
  endfunction

endpackage

// File: rtl/ram_8x72.sv
// 8 x 72 storage: one synchronous write port, one combinational read port.
// Contents are never reset. When the read port is disabled it holds the
// last value it presented rather than floating.
module ram_8x72 (
  input  logic [2:0]  R0_addr,
  input  logic        R0_en,
  input  logic        R0_clk,
  output logic [71:0] R0_data,
  input  logic [2:0]  W0_addr,
  input  logic        W0_en,
  input  logic        W0_clk,
  input  logic [71:0] W0_data
);

  logic [71:0] mem_q [0:7];
  logic [71:0] hold_q;

  // Write port: capture data into the addressed entry on an enabled edge.
  always_ff @(posedge W0_clk) begin
    if (W0_en) begin
      mem_q[W0_addr] <= W0_data;
    end
  end

  // Read-port holding register: remembers the last presented read value.
  always_ff @(posedge R0_clk) begin
    hold_q <= R0_data;
  end

  // Read port: live lookup while enabled, otherwise the held value.
  always_comb begin
    R0_data = hold_q;
    if (R0_en) begin
      R0_data = mem_q[R0_addr];
    end else begin
      R0_data = hold_q;
    end
  end

endmodule

// File: rtl/queue_8x72_ctrl.sv
// Eight-entry, 72-bit ready/valid queue around a ram_8x72 instance.
// A separate occupancy counter disambiguates full from empty when the
// pointers are equal. No pipe-through when full, no flow-through when empty.
module queue_8x72_ctrl
  import queue_8x72_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        enq_valid,
  output logic        enq_ready,
  input  logic [71:0] enq_bits,
  output logic        deq_valid,
  input  logic        deq_ready,
  output logic [71:0] deq_bits,
  input  logic        flush,
  output logic [3:0]  count,
  output logic        overflow_err
);

  logic [PTR_W-1:0] enq_ptr_q, enq_ptr_d;
  logic [PTR_W-1:0] deq_ptr_q, deq_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  logic             enq_fire_s;
  logic             deq_fire_s;
  logic             ram_we_s;
  payload_t         ram_rdata_s;

  // Handshakes depend only on registered occupancy, never on flush.
  always_comb begin
    enq_ready  = (count_q != CNT_FULL);
    deq_valid  = (count_q != CNT_EMPTY);
    enq_fire_s = enq_valid & enq_ready;
    deq_fire_s = deq_valid & deq_ready;
    // Flush suppresses the write; reset blocks it so nothing lands while held.
    ram_we_s   = enq_fire_s & ~flush & ~reset;
  end

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    enq_ptr_d  = enq_ptr_q;
    deq_ptr_d  = deq_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (enq_valid & (count_q == CNT_FULL) & ~flush);
    if (flush) begin
      enq_ptr_d = 3'd0;
      deq_ptr_d = 3'd0;
      count_d   = 4'd0;
    end else begin
      if (enq_fire_s) begin
        enq_ptr_d = ptr_inc(enq_ptr_q);
      end else begin
        enq_ptr_d = enq_ptr_q;
      end
      if (deq_fire_s) begin
        deq_ptr_d = ptr_inc(deq_ptr_q);
      end else begin
        deq_ptr_d = deq_ptr_q;
      end
      case ({enq_fire_s, deq_fire_s})
        2'b10:   count_d = count_q + 4'd1;
        2'b01:   count_d = count_q - 4'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; reset clears occupancy and the flag asynchronously.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      enq_ptr_q  <= 3'd0;
      deq_ptr_q  <= 3'd0;
      count_q    <= 4'd0;
      overflow_q <= 1'b0;
    end else begin
      enq_ptr_q  <= enq_ptr_d;
      deq_ptr_q  <= deq_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  ram_8x72 u_ram (
    .R0_addr (deq_ptr_q),
    .R0_en   (deq_valid),
    .R0_clk  (clock),
    .R0_data (ram_rdata_s),
    .W0_addr (enq_ptr_q),
    .W0_en   (ram_we_s),
    .W0_clk  (clock),
    .W0_data (enq_bits)
  );

  // Head payload is exposed only while an entry is present.
  always_comb begin
    if (deq_valid) begin
      deq_bits = ram_rdata_s;
    end else begin
      deq_bits = 72'd0;
    end
    count        = count_q;
    overflow_err = overflow_q;
  end

endmodule

// File: tb/tb_queue_8x72_ctrl.sv
// Self-checking bench for queue_8x72_ctrl against a SystemVerilog-queue model.
module tb_queue_8x72_ctrl;

  logic        clock;
  logic        reset;
  logic        enq_valid;
  logic        enq_ready;
  logic [71:0] enq_bits;
  logic        deq_valid;
  logic        deq_ready;
  logic [71:0] deq_bits;
  logic        flush;
  logic [3:0]  count;
  logic        overflow_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [71:0] mq[$];
  logic        m_ovf;

  queue_8x72_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .enq_valid    (enq_valid),
    .enq_ready    (enq_ready),
    .enq_bits     (enq_bits),
    .deq_valid    (deq_valid),
    .deq_ready    (deq_ready),
    .deq_bits     (deq_bits),
    .flush        (flush),
    .count        (count),
    .overflow_err (overflow_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [71:0] rnd72();
    return {8'($urandom), 32'($urandom), 32'($urandom)};
  endfunction

  function automatic logic [71:0] m_head();
    if (mq.size() > 0) return mq[0];
    return 72'd0;
  endfunction

  // Advance the model by the rules of one clock edge, then the DUT.
  task automatic tick();
    int sz;
    bit fe;
    bit fd;
    sz = mq.size();
    fe = enq_valid && (sz < 8);
    fd = deq_ready && (sz > 0);
    if (enq_valid && sz == 8 && !flush) m_ovf = 1'b1;
    if (flush) mq.delete();
    else begin
      if (fd) void'(mq.pop_front());
      if (fe) mq.push_back(enq_bits);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    enq_valid = 1'b0; deq_ready = 1'b0; flush = 1'b0; enq_bits = 72'd0;
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) begin
      enq_valid = 1'b1; enq_bits = rnd72();
      tick();
    end
    idle();
  endtask

  task automatic drain_all();
    deq_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    mq.delete(); m_ovf = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    n_tests++;
    if ({count, enq_ready, deq_valid, deq_bits, overflow_err} !== {4'd0, 1'b1, 1'b0, 72'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got cnt=%0d rdy=%b vld=%b bits=%h ovf=%b want 0 1 0 0 0",
               count, enq_ready, deq_valid, deq_bits, overflow_err);
    end
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 8; i++) begin
      enq_valid = 1'b1; enq_bits = 72'(i);
      tick();
      n_tests++;
      if (count !== 4'(i)) begin
        n_fail++; $display("FAIL fill_count: got %0d want %0d", count, i);
      end
    end
    idle();
    n_tests++;
    if (enq_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_ready: got %b want 0", enq_ready);
    end
    deq_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      n_tests++;
      if (deq_valid !== 1'b1 || deq_bits !== 72'(i)) begin
        n_fail++; $display("FAIL drain_order: got vld=%b bits=%h want 1 %h", deq_valid, deq_bits, 72'(i));
      end
      tick();
    end
    idle();
    n_tests++;
    if (count !== 4'd0 || deq_valid !== 1'b0) begin
      n_fail++; $display("FAIL drained: got cnt=%0d vld=%b want 0 0", count, deq_valid);
    end
  endtask

  task automatic test_full_deq();
    fill(8);
    enq_valid = 1'b1; enq_bits = 72'hDEAD; deq_ready = 1'b1;
    n_tests++;
    if (enq_ready !== 1'b0 || deq_bits !== m_head()) begin
      n_fail++; $display("FAIL full_deq_pre: got rdy=%b bits=%h want 0 %h", enq_ready, deq_bits, m_head());
    end
    tick();
    deq_ready = 1'b0;
    n_tests++;
    if (count !== 4'd7 || deq_bits !== m_head()) begin
      n_fail++; $display("FAIL full_deq_only: got cnt=%0d bits=%h want 7 %h", count, deq_bits, m_head());
    end
    tick();
    idle();
    n_tests++;
    if (count !== 4'd8 || overflow_err !== m_ovf) begin
      n_fail++; $display("FAIL dead_accept: got cnt=%0d ovf=%b want 8 %b", count, overflow_err, m_ovf);
    end
    deq_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (deq_bits !== m_head() || (i == 7 && deq_bits !== 72'hDEAD)) begin
        n_fail++; $display("FAIL full_deq_drain: got %h want %h", deq_bits, m_head());
      end
      tick();
    end
    idle();
  endtask

  task automatic test_wrap();
    fill(3);
    enq_valid = 1'b1; deq_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      enq_bits = rnd72();
      n_tests++;
      if (deq_bits !== m_head()) begin
        n_fail++; $display("FAIL wrap_order: got %h want %h", deq_bits, m_head());
      end
      tick();
      n_tests++;
      if (count !== 4'd3) begin
        n_fail++; $display("FAIL wrap_count: got %0d want 3", count);
      end
    end
    idle();
    drain_all();
  endtask

  task automatic test_no_flowthrough();
    enq_valid = 1'b1; enq_bits = 72'hABC;
    n_tests++;
    if (deq_valid !== 1'b0 || deq_bits !== 72'd0) begin
      n_fail++; $display("FAIL flowthrough: got vld=%b bits=%h want 0 0", deq_valid, deq_bits);
    end
    tick();
    idle();
    n_tests++;
    if (deq_valid !== 1'b1 || deq_bits !== 72'hABC) begin
      n_fail++; $display("FAIL next_cycle: got vld=%b bits=%h want 1 abc", deq_valid, deq_bits);
    end
    drain_all();
  endtask

  task automatic test_flush();
    fill(5);
    flush = 1'b1; enq_valid = 1'b1; deq_ready = 1'b1; enq_bits = rnd72();
    n_tests++;
    if (enq_ready !== 1'b1 || deq_valid !== 1'b1 || count !== 4'd5) begin
      n_fail++; $display("FAIL flush_pre: got rdy=%b vld=%b cnt=%0d want 1 1 5", enq_ready, deq_valid, count);
    end
    tick();
    idle();
    n_tests++;
    if (count !== 4'd0 || deq_valid !== 1'b0 || deq_bits !== 72'd0) begin
      n_fail++; $display("FAIL flush_post: got cnt=%0d vld=%b bits=%h want 0 0 0", count, deq_valid, deq_bits);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      enq_valid = 1'($urandom_range(0, 1));
      deq_ready = ($urandom_range(0, 2) == 0);
      flush     = ($urandom_range(0, 40) == 0);
      enq_bits  = rnd72();
      n_tests++;
      if ({count, enq_ready, deq_valid, deq_bits, overflow_err} !==
          {4'(mq.size()), mq.size() != 8, mq.size() != 0, m_head(), m_ovf}) begin
        n_fail++;
        $display("FAIL random[%0d]: got cnt=%0d rdy=%b vld=%b bits=%h ovf=%b want cnt=%0d bits=%h ovf=%b",
                 i, count, enq_ready, deq_valid, deq_bits, overflow_err, mq.size(), m_head(), m_ovf);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_reset_mid();
    fill(4);
    enq_valid = 1'b1; deq_ready = 1'b1; enq_bits = rnd72();
    reset = 1'b1;
    mq.delete(); m_ovf = 1'b0;
    #1;
    n_tests++;
    if ({count, enq_ready, deq_valid, deq_bits, overflow_err} !== {4'd0, 1'b1, 1'b0, 72'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_async: got cnt=%0d rdy=%b vld=%b bits=%h ovf=%b want 0 1 0 0 0",
               count, enq_ready, deq_valid, deq_bits, overflow_err);
    end
    @(posedge clock); #1;
    n_tests++;
    if (count !== 4'd0 || deq_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_hold: got cnt=%0d vld=%b want 0 0", count, deq_valid);
    end
    reset = 1'b0;
    idle();
    enq_valid = 1'b1; enq_bits = 72'h5A5A_1234;
    tick();
    idle();
    n_tests++;
    if (deq_valid !== 1'b1 || deq_bits !== 72'h5A5A_1234 || count !== 4'd1) begin
      n_fail++; $display("FAIL post_reset_first: got vld=%b bits=%h cnt=%0d want 1 5a5a1234 1",
                         deq_valid, deq_bits, count);
    end
    drain_all();
  endtask

  task automatic test_overflow();
    fill(8);
    n_tests++;
    if (overflow_err !== 1'b0) begin
      n_fail++; $display("FAIL ovf_clear: got %b want 0", overflow_err);
    end
    enq_valid = 1'b1; enq_bits = rnd72();
    tick();
    idle();
    n_tests++;
    if (overflow_err !== 1'b1 || count !== 4'd8) begin
      n_fail++; $display("FAIL ovf_set: got ovf=%b cnt=%0d want 1 8", overflow_err, count);
    end
    deq_ready = 1'b1;
    repeat (3) tick();
    idle();
    n_tests++;
    if (overflow_err !== 1'b1 || count !== 4'd5) begin
      n_fail++; $display("FAIL ovf_sticky: got ovf=%b cnt=%0d want 1 5", overflow_err, count);
    end
    #2;
    reset = 1'b1;
    #1;
    n_tests++;
    if ({count, enq_ready, deq_valid, deq_bits, overflow_err} !== {4'd0, 1'b1, 1'b0, 72'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL ovf_reset: got cnt=%0d rdy=%b vld=%b bits=%h ovf=%b want 0 1 0 0 0",
               count, enq_ready, deq_valid, deq_bits, overflow_err);
    end
    mq.delete(); m_ovf = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  initial begin
    m_ovf = 1'b0;
    test_reset();
    test_fill_drain();
    test_full_deq();
    test_reset_mid();
    test_wrap();
    test_no_flowthrough();
    test_flush();
    test_random();
    test_reset_mid();
    test_overflow();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
